// File: rtl/mac_rx_frame_arbiter_pkg.sv
// Shared types for the 40G switch ingress path: arbiter FSM states and the
// AXI-Stream beat layout used between MAC ports and the switch core.
package sw40g_pkg;

  localparam int NPORT  = 4;
  localparam int DATA_W = 64;
  localparam int KEEP_W = 8;
  localparam int PORT_W = 2;

  typedef enum logic [1:0] {IDLE, XFER, DRAIN} arb_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tlast;
  } axis_beat_t;

endpackage

// File: rtl/mac_rx_frame_arbiter_rr_arb4.sv
// Four-way rotate-priority encoder: the first requester after last_grant wins.
// Shared with the TX-side scheduler.
module rr_arb4 (
  input  logic [3:0] req,
  input  logic [1:0] last_grant,
  output logic [1:0] grant,
  output logic       any
);

  logic [1:0] idx;

  // scan last_grant+1 .. last_grant+4 (wrapping) and keep the first hit
  always_comb begin
    grant = 2'd0;
    any   = 1'b0;
    idx   = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      idx = last_grant + 2'(i);
      if (!any && req[idx]) begin
        grant = idx;
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mac_rx_frame_arbiter.sv
// Frame-granular round-robin merge of four MAC RX streams onto one uplink,
// with a beat-limit watchdog that truncates runaway frames.
module mac_rx_frame_arbiter
  import sw40g_pkg::*;
#(
  parameter int NPORT     = 4,
  parameter int MAX_BEATS = 1200,
  parameter int CNT_W     = 32
) (
  input  logic                          user_clk,
  input  logic                          reset,
  input  logic [NPORT-1:0]              port_en,
  input  logic [NPORT-1:0][DATA_W-1:0]  s_axis_tdata,
  input  logic [NPORT-1:0][KEEP_W-1:0]  s_axis_tkeep,
  input  logic [NPORT-1:0]              s_axis_tvalid,
  input  logic [NPORT-1:0]              s_axis_tlast,
  output logic [NPORT-1:0]              s_axis_tready,
  output logic [DATA_W-1:0]             m_axis_tdata,
  output logic [KEEP_W-1:0]             m_axis_tkeep,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  output logic [PORT_W-1:0]             m_axis_tuser,
  input  logic                          m_axis_tready,
  output logic                          trunc_pulse,
  output logic [NPORT-1:0][CNT_W-1:0]   frame_cnt,
  output logic [NPORT-1:0][CNT_W-1:0]   trunc_cnt
);

  localparam int BEAT_W = $clog2(MAX_BEATS + 1);

  arb_state_t        state, next_state;
  logic [PORT_W-1:0] grant, last_grant, arb_grant;
  logic              arb_any;
  logic [BEAT_W-1:0] beat_cnt;
  logic              load, accept, at_limit;
  axis_beat_t        in_beat;

  assign load     = !m_axis_tvalid || m_axis_tready;
  assign in_beat  = {s_axis_tdata[grant], s_axis_tkeep[grant], s_axis_tlast[grant]};
  assign accept   = s_axis_tvalid[grant] && s_axis_tready[grant];
  assign at_limit = (beat_cnt + BEAT_W'(1)) == BEAT_W'(MAX_BEATS);

  rr_arb4 u_arb (
    .req        (s_axis_tvalid & port_en),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .any        (arb_any)
  );

  // DRAIN swallows the rest of a truncated frame without waiting on the uplink
  always_comb begin
    s_axis_tready = {NPORT{1'b0}};
    if (state == XFER) begin
      s_axis_tready[grant] = load;
    end else if (state == DRAIN) begin
      s_axis_tready[grant] = 1'b1;
    end else begin
      s_axis_tready = {NPORT{1'b0}};
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (arb_any) next_state = XFER;
        else         next_state = IDLE;
      end
      XFER: begin
        if (accept && in_beat.tlast) next_state = IDLE;
        else if (accept && at_limit) next_state = DRAIN;
        else                         next_state = XFER;
      end
      DRAIN: begin
        if (accept && in_beat.tlast) next_state = IDLE;
        else                         next_state = DRAIN;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // tlast outranks the limit, so a frame ending exactly on MAX_BEATS is normal
  always_ff @(posedge user_clk) begin
    if (reset) begin
      grant         <= '0;
      last_grant    <= PORT_W'(NPORT - 1);
      beat_cnt      <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tuser  <= '0;
      trunc_pulse   <= 1'b0;
      frame_cnt     <= '0;
      trunc_cnt     <= '0;
    end else begin
      trunc_pulse <= 1'b0;
      if (state == IDLE && arb_any) begin
        grant    <= arb_grant;
        beat_cnt <= '0;
      end
      if (load) begin
        if (state == XFER && accept) begin
          m_axis_tvalid <= 1'b1;
          m_axis_tdata  <= in_beat.tdata;
          m_axis_tkeep  <= in_beat.tkeep;
          m_axis_tlast  <= in_beat.tlast || at_limit;
          m_axis_tuser  <= grant;
        end else begin
          m_axis_tvalid <= 1'b0;
        end
      end
      if (state == XFER && accept) begin
        beat_cnt <= beat_cnt + BEAT_W'(1);
        if (in_beat.tlast) begin
          frame_cnt[grant] <= frame_cnt[grant] + CNT_W'(1);
          last_grant       <= grant;
        end else if (at_limit) begin
          trunc_pulse      <= 1'b1;
          trunc_cnt[grant] <= trunc_cnt[grant] + CNT_W'(1);
          last_grant       <= grant;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_rx_frame_arbiter.sv
// Randomized bench for mac_rx_frame_arbiter: per-port frame queues feed the DUT
// and a frame-level round-robin model predicts the uplink beat sequence.
module tb_mac_rx_frame_arbiter;

  localparam int MAX_B = 8;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic [1:0]  u;
  } rec_t;

  logic                 user_clk = 1'b0;
  logic                 reset = 1'b1;
  logic [3:0]           port_en = '0;
  logic [3:0][63:0]     s_axis_tdata = '0;
  logic [3:0][7:0]      s_axis_tkeep = '0;
  logic [3:0]           s_axis_tvalid = '0;
  logic [3:0]           s_axis_tlast = '0;
  logic [3:0]           s_axis_tready;
  logic [63:0]          m_axis_tdata;
  logic [7:0]           m_axis_tkeep;
  logic                 m_axis_tvalid;
  logic                 m_axis_tlast;
  logic [1:0]           m_axis_tuser;
  logic                 m_axis_tready = 1'b0;
  logic                 trunc_pulse;
  logic [3:0][31:0]     frame_cnt;
  logic [3:0][31:0]     trunc_cnt;

  mac_rx_frame_arbiter #(.NPORT(4), .MAX_BEATS(MAX_B), .CNT_W(32)) dut (
    .user_clk(user_clk), .reset(reset), .port_en(port_en),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready),
    .trunc_pulse(trunc_pulse), .frame_cnt(frame_cnt), .trunc_cnt(trunc_cnt)
  );

  always #5 user_clk = ~user_clk;

  rec_t src_q[4][$];
  rec_t exp_q[$];
  rec_t obs_q[$];
  int   exp_fc[4];
  int   exp_tc[4];
  int   model_lg;
  int   exp_trunc;
  int   n_checks = 0;
  int   n_fail = 0;
  int   last_fire, trunc_seen, stall_viol;
  bit   timed_out;
  bit   tready_seen[4];
  logic snap_valid, snap_cnt_nz;
  logic [3:0] snap_ready;

  initial begin
    #5000000;
    $display("FAIL global_timeout reached without finishing");
    $fatal(1, "global timeout");
  end

  task automatic add_frame(input int p, input int len);
    rec_t r;
    for (int i = 0; i < len; i++) begin
      r.d = {$urandom, $urandom};
      r.k = 8'($urandom);
      r.l = (i == len - 1);
      r.u = 2'(p);
      src_q[p].push_back(r);
    end
  endtask

  // Frame-level model: pick ports round-robin, cut frames longer than MAX_B.
  task automatic build_expected(input logic [3:0] en);
    rec_t q[4][$];
    rec_t b;
    int   p, n;
    bit   found, done;
    exp_q.delete();
    exp_trunc = 0;
    for (int i = 0; i < 4; i++) q[i] = src_q[i];
    forever begin
      found = 0;
      p = 0;
      for (int i = 1; i <= 4; i++) begin
        p = (model_lg + i) % 4;
        if (en[p] && q[p].size() > 0) begin
          found = 1;
          break;
        end
      end
      if (!found) break;
      n = 0;
      done = 0;
      while (!done) begin
        b = q[p].pop_front();
        n++;
        done = b.l;
        if (n <= MAX_B) begin
          if (n == MAX_B) b.l = 1'b1;
          exp_q.push_back(b);
        end
      end
      if (n > MAX_B) begin
        exp_tc[p]++;
        exp_trunc++;
      end else begin
        exp_fc[p]++;
      end
      model_lg = p;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge user_clk);
    @(negedge user_clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_fc[i] = 0;
      exp_tc[i] = 0;
    end
    model_lg = 3;
  endtask

  // rdy_mode: 0 always ready, 1 pattern 1,0,0, 2 random; rst_at>=0 resets after that many port-0 beats
  task automatic run(input int budget, input int rdy_mode, input logic [3:0] en, input int rst_at);
    bit   acc[4];
    bit   fire, busy;
    rec_t ob;
    int   acc0;
    acc0 = 0;
    obs_q.delete();
    last_fire = -1;
    trunc_seen = 0;
    stall_viol = 0;
    timed_out = 0;
    for (int i = 0; i < 4; i++) tready_seen[i] = 0;
    port_en = en;
    for (int cyc = 0; ; cyc++) begin
      busy = 0;
      for (int p = 0; p < 4; p++) if (en[p] && src_q[p].size() > 0) busy = 1;
      if (rst_at < 0 && !busy && obs_q.size() >= exp_q.size()) break;
      if (cyc >= budget) begin
        timed_out = 1;
        break;
      end
      for (int p = 0; p < 4; p++) begin
        if (src_q[p].size() > 0) begin
          s_axis_tvalid[p] = 1'b1;
          s_axis_tdata[p]  = src_q[p][0].d;
          s_axis_tkeep[p]  = src_q[p][0].k;
          s_axis_tlast[p]  = src_q[p][0].l;
        end else begin
          s_axis_tvalid[p] = 1'b0;
          s_axis_tdata[p]  = '0;
          s_axis_tkeep[p]  = '0;
          s_axis_tlast[p]  = 1'b0;
        end
      end
      case (rdy_mode)
        0: m_axis_tready = 1'b1;
        1: m_axis_tready = (cyc % 3 == 0);
        default: m_axis_tready = ($urandom_range(0, 3) != 0);
      endcase
      reset = (rst_at >= 0 && acc0 == rst_at);
      #1;
      for (int p = 0; p < 4; p++) begin
        acc[p] = s_axis_tvalid[p] && s_axis_tready[p];
        if (s_axis_tready[p]) tready_seen[p] = 1;
      end
      fire = m_axis_tvalid && m_axis_tready;
      ob = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
      if (m_axis_tvalid && !m_axis_tready && s_axis_tready != 4'b0000) stall_viol++;
      @(posedge user_clk);
      #1;
      if (reset) begin
        snap_valid  = m_axis_tvalid;
        snap_ready  = s_axis_tready;
        snap_cnt_nz = (frame_cnt != '0) || (trunc_cnt != '0);
        @(negedge user_clk);
        reset = 1'b0;
        return;
      end
      for (int p = 0; p < 4; p++) begin
        if (acc[p]) begin
          void'(src_q[p].pop_front());
          if (p == 0) acc0++;
        end
      end
      if (fire) begin
        obs_q.push_back(ob);
        last_fire = cyc;
      end
      if (trunc_pulse) trunc_seen++;
      @(negedge user_clk);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_tvalid got %b exp 0", m_axis_tvalid); end
    n_checks++; if (m_axis_tlast !== 1'b0) begin n_fail++; $display("FAIL rst_tlast got %b exp 0", m_axis_tlast); end
    n_checks++; if ({m_axis_tdata, m_axis_tkeep, m_axis_tuser} !== 74'd0) begin n_fail++; $display("FAIL rst_data got %h exp 0", {m_axis_tdata, m_axis_tkeep, m_axis_tuser}); end
    n_checks++; if (s_axis_tready !== 4'b0000) begin n_fail++; $display("FAIL rst_tready got %b exp 0000", s_axis_tready); end
    n_checks++; if (trunc_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_trunc got %b exp 0", trunc_pulse); end
    n_checks++; if (frame_cnt !== '0 || trunc_cnt !== '0) begin n_fail++; $display("FAIL rst_counters got %h/%h exp 0", frame_cnt, trunc_cnt); end
  endtask

  task automatic test_single_port();
    for (int f = 0; f < 3; f++) add_frame(2, 4);
    build_expected(4'b1111);
    run(200, 0, 4'b1111, -1);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL single_timeout got 1 exp 0"); end
    n_checks++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL single_len got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL single_beat[%0d] got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
    n_checks++; if (last_fire !== 15) begin n_fail++; $display("FAIL single_timing last beat cycle got %0d exp 15", last_fire); end
    for (int p = 0; p < 4; p++) begin
      n_checks++; if (frame_cnt[p] !== 32'(exp_fc[p]) || trunc_cnt[p] !== 32'(exp_tc[p])) begin n_fail++; $display("FAIL single_cnt[%0d] got %0d/%0d exp %0d/%0d", p, frame_cnt[p], trunc_cnt[p], exp_fc[p], exp_tc[p]); end
    end
  endtask

  task automatic test_all_ports();
    do_reset();
    for (int p = 0; p < 4; p++) add_frame(p, 3);
    build_expected(4'b1111);
    run(200, 0, 4'b1111, -1);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL allp_timeout got 1 exp 0"); end
    n_checks++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL allp_len got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL allp_beat[%0d] got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
    for (int p = 0; p < 4; p++) begin
      n_checks++; if (frame_cnt[p] !== 32'(exp_fc[p])) begin n_fail++; $display("FAIL allp_cnt[%0d] got %0d exp %0d", p, frame_cnt[p], exp_fc[p]); end
    end
  endtask

  task automatic test_stall();
    add_frame(1, 5);
    build_expected(4'b1111);
    run(200, 1, 4'b1111, -1);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL stall_timeout got 1 exp 0"); end
    n_checks++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL stall_len got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL stall_beat[%0d] got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
    n_checks++; if (stall_viol !== 0) begin n_fail++; $display("FAIL stall_tready high during stall got %0d cycles exp 0", stall_viol); end
    n_checks++; if (frame_cnt[1] !== 32'(exp_fc[1])) begin n_fail++; $display("FAIL stall_cnt got %0d exp %0d", frame_cnt[1], exp_fc[1]); end
  endtask

  task automatic test_truncation();
    add_frame(0, 12);
    add_frame(0, 1);
    add_frame(1, MAX_B);
    build_expected(4'b1111);
    run(300, 0, 4'b1111, -1);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL trunc_timeout got 1 exp 0"); end
    n_checks++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL trunc_len got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL trunc_beat[%0d] got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
    n_checks++; if (trunc_seen !== exp_trunc) begin n_fail++; $display("FAIL trunc_pulse cycles got %0d exp %0d", trunc_seen, exp_trunc); end
    for (int p = 0; p < 4; p++) begin
      n_checks++; if (frame_cnt[p] !== 32'(exp_fc[p]) || trunc_cnt[p] !== 32'(exp_tc[p])) begin n_fail++; $display("FAIL trunc_cnt[%0d] got %0d/%0d exp %0d/%0d", p, frame_cnt[p], trunc_cnt[p], exp_fc[p], exp_tc[p]); end
    end
  endtask

  task automatic test_port_en();
    for (int p = 0; p < 4; p++)
      for (int f = 0; f < 3; f++) add_frame(p, $urandom_range(1, 5));
    build_expected(4'b1010);
    run(400, 0, 4'b1010, -1);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL pen_timeout got 1 exp 0"); end
    n_checks++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL pen_len got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL pen_beat[%0d] got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
    n_checks++; if (tready_seen[0] || tready_seen[2]) begin n_fail++; $display("FAIL pen_disabled_ready got p0=%0d p2=%0d exp 0/0", tready_seen[0], tready_seen[2]); end
    src_q[0].delete();
    src_q[2].delete();
  endtask

  task automatic test_random();
    for (int p = 0; p < 4; p++)
      for (int f = 0; f < 3; f++) add_frame(p, $urandom_range(1, 11));
    build_expected(4'b1111);
    run(3000, 2, 4'b1111, -1);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL rand_timeout got 1 exp 0"); end
    n_checks++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rand_len got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_beat[%0d] got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
    n_checks++; if (trunc_seen !== exp_trunc) begin n_fail++; $display("FAIL rand_trunc_pulse got %0d exp %0d", trunc_seen, exp_trunc); end
    for (int p = 0; p < 4; p++) begin
      n_checks++; if (frame_cnt[p] !== 32'(exp_fc[p]) || trunc_cnt[p] !== 32'(exp_tc[p])) begin n_fail++; $display("FAIL rand_cnt[%0d] got %0d/%0d exp %0d/%0d", p, frame_cnt[p], trunc_cnt[p], exp_fc[p], exp_tc[p]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    exp_q.delete();
    add_frame(0, 6);
    run(50, 0, 4'b1111, 3);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL midrst_timeout got 1 exp 0"); end
    n_checks++; if (snap_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_tvalid got %b exp 0", snap_valid); end
    n_checks++; if (snap_ready !== 4'b0000) begin n_fail++; $display("FAIL midrst_tready got %b exp 0000", snap_ready); end
    n_checks++; if (snap_cnt_nz !== 1'b0) begin n_fail++; $display("FAIL midrst_counters got nonzero=%b exp 0", snap_cnt_nz); end
    for (int i = 0; i < 4; i++) begin
      exp_fc[i] = 0;
      exp_tc[i] = 0;
    end
    model_lg = 3;
    add_frame(1, 2);
    add_frame(3, 2);
    build_expected(4'b1111);
    run(200, 0, 4'b1111, -1);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL midrst2_timeout got 1 exp 0"); end
    n_checks++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL midrst2_len got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL midrst2_beat[%0d] got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
    for (int p = 0; p < 4; p++) begin
      n_checks++; if (frame_cnt[p] !== 32'(exp_fc[p])) begin n_fail++; $display("FAIL midrst2_cnt[%0d] got %0d exp %0d", p, frame_cnt[p], exp_fc[p]); end
    end
  endtask

  initial begin
    model_lg = 3;
    repeat (2) @(negedge user_clk);
    test_reset();
    test_single_port();
    test_all_ports();
    test_stall();
    test_truncation();
    test_port_en();
    test_random();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
